// File: rtl/alu_pkg.sv
// Shared ALU op codes and the multiply sequencer state encoding.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_MOV = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_CLC = 5'd23;
  localparam logic [ALU_OP_W-1:0] ALU_OP_STC = 5'd24;
  localparam logic [ALU_OP_W-1:0] ALU_OP_CLZ = 5'd25;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SEZ = 5'd26;
  localparam logic [ALU_OP_W-1:0] ALU_OP_CLS = 5'd27;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SES = 5'd28;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    RST_C = 3'd4,
    RST_Z = 3'd5,
    RST_S = 3'd6,
    DONE  = 3'd7
  } mulState_t;

endpackage

// File: rtl/alu_issue_mux.sv
// CPU-level 2:1 mux choosing who drives the shared ALU operands and op code.
module alu_issue_mux
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic                sel,
  input  logic [BITS-1:0]     coreA,
  input  logic [BITS-1:0]     coreB,
  input  logic [ALU_OP_W-1:0] coreOp,
  input  logic [BITS-1:0]     seqA,
  input  logic [BITS-1:0]     seqB,
  input  logic [ALU_OP_W-1:0] seqOp,
  output logic [BITS-1:0]     aluA_c,
  output logic [BITS-1:0]     aluB_c,
  output logic [ALU_OP_W-1:0] aluOp_c
);

  always_comb begin
    aluA_c  = sel ? seqA  : coreA;
    aluB_c  = sel ? seqB  : coreB;
    aluOp_c = sel ? seqOp : coreOp;
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that borrows the shared ALU adder and restores
// the ALU C/Z/S flags before signalling completion.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned BITS  = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [BITS-1:0]     a_in,
  input  logic [BITS-1:0]     b_in,
  output logic                busy,
  output logic                done,
  output logic [BITS-1:0]     result_lo,
  output logic [BITS-1:0]     result_hi,
  output logic                alu_sel,
  output logic [BITS-1:0]     alu_A,
  output logic [BITS-1:0]     alu_B,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [BITS-1:0]     alu_out,
  input  logic                alu_C,
  input  logic                alu_Z,
  input  logic                alu_S
);

  mulState_t           state, stateNext;
  logic [BITS-1:0]     mcand, mcandNext;
  logic [BITS-1:0]     mplier, mplierNext;
  logic [BITS-1:0]     acc, accNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic                added, addedNext;
  logic                sC, sCNext, sZ, sZNext, sS, sSNext;
  logic                cin;
  logic                busyNext, doneNext, aluSelNext;
  logic [BITS-1:0]     aluANext, aluBNext;
  logic [ALU_OP_W-1:0] aluOpNext;
  logic [BITS-1:0]     resultLoNext, resultHiNext;

  // Next-state, datapath and (pre-registered) ALU drive for the state being entered.
  always_comb begin
    stateNext    = state;
    mcandNext    = mcand;
    mplierNext   = mplier;
    accNext      = acc;
    cntNext      = cnt;
    addedNext    = added;
    sCNext       = sC;
    sZNext       = sZ;
    sSNext       = sS;
    resultLoNext = result_lo;
    resultHiNext = result_hi;
    cin          = added ? alu_C : 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mcandNext  = a_in;
          mplierNext = b_in;
          accNext    = '0;
          cntNext    = CNT_W'(BITS);
          stateNext  = SAVE;
        end
      end
      SAVE: begin
        sCNext    = alu_C;
        sZNext    = alu_Z;
        sSNext    = alu_S;
        stateNext = ADD;
      end
      ADD: begin
        addedNext = mplier[0];
        stateNext = SHIFT;
      end
      SHIFT: begin
        {accNext, mplierNext} = {cin, alu_out, mplier[BITS-1:1]};
        cntNext   = cnt - CNT_W'(1);
        stateNext = (cnt == CNT_W'(1)) ? RST_C : ADD;
      end
      RST_C: stateNext = RST_Z;
      RST_Z: stateNext = RST_S;
      RST_S: begin
        resultHiNext = acc;
        resultLoNext = mplier;
        stateNext    = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    busyNext   = (stateNext != IDLE);
    doneNext   = (stateNext == DONE);
    aluSelNext = busyNext && (stateNext != DONE);
    aluANext   = '0;
    aluBNext   = '0;
    aluOpNext  = ALU_OP_MOV;

    case (stateNext)
      ADD: begin
        if (mplierNext[0]) begin
          aluOpNext = ALU_OP_ADD;
          aluANext  = accNext;
          aluBNext  = mcandNext;
        end else begin
          aluBNext  = accNext;
        end
      end
      RST_C:   aluOpNext = sCNext ? ALU_OP_STC : ALU_OP_CLC;
      RST_Z:   aluOpNext = sZNext ? ALU_OP_SEZ : ALU_OP_CLZ;
      RST_S:   aluOpNext = sSNext ? ALU_OP_SES : ALU_OP_CLS;
      default: aluOpNext = ALU_OP_MOV;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      added     <= 1'b0;
      sC        <= 1'b0;
      sZ        <= 1'b0;
      sS        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_sel   <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= ALU_OP_MOV;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      state     <= stateNext;
      mcand     <= mcandNext;
      mplier    <= mplierNext;
      acc       <= accNext;
      cnt       <= cntNext;
      added     <= addedNext;
      sC        <= sCNext;
      sZ        <= sZNext;
      sS        <= sSNext;
      busy      <= busyNext;
      done      <= doneNext;
      alu_sel   <= aluSelNext;
      alu_A     <= aluANext;
      alu_B     <= aluBNext;
      alu_op    <= aluOpNext;
      result_lo <= resultLoNext;
      result_hi <= resultHiNext;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a registered behavioural ALU behind the issue mux.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int unsigned BITS = 16;
  localparam int unsigned LAT  = 5 + 2 * BITS;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] aIn = '0, bIn = '0;
  logic            busy, done, alu_sel;
  logic [BITS-1:0] result_lo, result_hi, alu_A, alu_B;
  logic [4:0]      alu_op;

  logic [BITS-1:0] coreA = '0, coreB = '0;
  logic [4:0]      coreOp = '0;
  logic [BITS-1:0] muxA, muxB;
  logic [4:0]      muxOp;
  logic [BITS-1:0] aluOut = '0;
  logic            aluC = 1'b0, aluZ = 1'b0, aluS = 1'b0;
  logic [BITS:0]   sum;

  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    logic [31:0] prod;
    int          dueCyc;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  alu_mul_seq #(.BITS(BITS), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .a_in(aIn), .b_in(bIn),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .alu_sel(alu_sel), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_out(aluOut), .alu_C(aluC), .alu_Z(aluZ), .alu_S(aluS)
  );

  alu_issue_mux #(.BITS(BITS)) issueMux (
    .sel(alu_sel), .coreA(coreA), .coreB(coreB), .coreOp(coreOp),
    .seqA(alu_A), .seqB(alu_B), .seqOp(alu_op),
    .aluA_c(muxA), .aluB_c(muxB), .aluOp_c(muxOp)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Registered ALU: move passes B, add sets C/Z/S, flag ops touch one flag.
  assign sum = {1'b0, muxA} + {1'b0, muxB};
  always @(posedge CLK) begin
    case (muxOp)
      ALU_OP_MOV: aluOut <= muxB;
      ALU_OP_ADD: begin
        aluOut <= sum[BITS-1:0];
        aluC   <= sum[BITS];
        aluZ   <= (sum[BITS-1:0] == '0);
        aluS   <= sum[BITS-1];
      end
      ALU_OP_CLC: aluC <= 1'b0;
      ALU_OP_STC: aluC <= 1'b1;
      ALU_OP_CLZ: aluZ <= 1'b0;
      ALU_OP_SEZ: aluZ <= 1'b1;
      ALU_OP_CLS: aluS <= 1'b0;
      ALU_OP_SES: aluS <= 1'b1;
      default: ;
    endcase
  end

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer plus idle-drive check.
  always @(negedge CLK) begin
    if (!RST) begin
      if (done) begin
        if (sbQ.size() == 0) begin
          checkEq("unexpected_done", 32'(done), 32'(0));
        end else begin
          sbEntry_t e;
          e = sbQ.pop_front();
          checkEq("result_hi", 32'(result_hi), 32'(e.prod[31:16]));
          checkEq("result_lo", 32'(result_lo), 32'(e.prod[15:0]));
          checkEq("done_latency", 32'(cyc), 32'(e.dueCyc));
        end
      end
      if (!alu_sel)
        checkEq("idle_drive", 32'(alu_A | alu_B | 16'(alu_op)), 32'(0));
    end
  end

  task automatic coreIssue(input logic [4:0] op);
    @(negedge CLK) coreOp = op;
    @(negedge CLK) coreOp = ALU_OP_MOV;
  endtask

  task automatic runMul(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input bit extraStarts, input bit chkOps,
                        input logic [14:0] expOps, input logic [2:0] expFlags);
    int tStart;
    sbEntry_t e;
    @(posedge CLK) #1;
    start  = 1'b1;
    aIn    = a;
    bIn    = b;
    tStart = cyc;
    e.prod   = 32'(a) * 32'(b);
    e.dueCyc = tStart + int'(LAT);
    sbQ.push_back(e);
    @(posedge CLK) #1;
    start = 1'b0;
    aIn   = 16'($urandom);
    bIn   = 16'($urandom);
    for (int k = 1; k <= int'(LAT) + 3; k++) begin
      @(negedge CLK);
      if (k == 1 || k == int'(LAT) || k == int'(LAT) + 1)
        checkEq($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= int'(LAT)));
      if (chkOps && k >= int'(LAT) - 3 && k <= int'(LAT) - 1)
        checkEq($sformatf("restore_op_k%0d", k), 32'(alu_op),
                32'(expOps[14 - 5 * (k - (int'(LAT) - 3)) -: 5]));
      if (extraStarts)
        start = (k == 5 || k == int'(LAT));
    end
    start = 1'b0;
    if (chkOps)
      checkEq("flags_after_done", 32'({aluC, aluZ, aluS}), 32'(expFlags));
  endtask

  initial begin
    int tStart;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkEq("rst_busy", 32'(busy), 32'(0));
    checkEq("rst_done", 32'(done), 32'(0));
    checkEq("rst_sel", 32'(alu_sel), 32'(0));
    checkEq("rst_drive", 32'(alu_A | alu_B | 16'(alu_op)), 32'(0));
    checkEq("rst_result", 32'({result_hi, result_lo}), 32'(0));
    RST = 1'b0;

    runMul(16'h0003, 16'h0005, 1'b0, 1'b0, '0, '0);
    runMul(16'h1234, 16'h5678, 1'b0, 1'b0, '0, '0);
    runMul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '0, '0);

    coreIssue(ALU_OP_STC);
    coreIssue(ALU_OP_CLZ);
    coreIssue(ALU_OP_SES);
    runMul(16'h0000, 16'h1234, 1'b0, 1'b1, {ALU_OP_STC, ALU_OP_CLZ, ALU_OP_SES}, 3'b101);

    coreIssue(ALU_OP_CLC);
    coreIssue(ALU_OP_SEZ);
    coreIssue(ALU_OP_CLS);
    runMul(16'hABCD, 16'h8001, 1'b0, 1'b1, {ALU_OP_CLC, ALU_OP_SEZ, ALU_OP_CLS}, 3'b010);

    runMul(16'h00FF, 16'h0101, 1'b1, 1'b0, '0, '0);

    // Abort mid-operation with reset; no done may follow.
    @(posedge CLK) #1;
    start  = 1'b1;
    aIn    = 16'h4321;
    bIn    = 16'h8765;
    tStart = cyc;
    @(posedge CLK) #1;
    start = 1'b0;
    while (cyc < tStart + 10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkEq("abort_busy", 32'(busy), 32'(0));
    checkEq("abort_sel", 32'(alu_sel), 32'(0));
    checkEq("abort_done", 32'(done), 32'(0));
    checkEq("abort_result", 32'({result_hi, result_lo}), 32'(0));
    repeat (LAT + 5) @(negedge CLK);

    runMul(16'h8001, 16'h7FFF, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++)
      runMul(16'($urandom), 16'($urandom), 1'b0, 1'b0, '0, '0);

    repeat (3) @(negedge CLK);
    checkEq("scoreboard_empty", 32'(sbQ.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
